// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: one instance per port.
// The requester drives the request fields; the arbiter returns grant and response.
interface dmem_arbiter_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [1:0]  size;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output req, we, addr, size, wdata,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, we, addr, size, wdata,
      output gnt, rvalid, rdata, err
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-ported data memory: port 0 (CPU) has priority,
// port 1 (loader) is guaranteed a grant after MAX_WAIT consecutive denials.
module dmem_arbiter #(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   dmem_arbiter_if.slave p0,
   dmem_arbiter_if.slave p1,
   output logic [31:0]   mem_addr,
   output logic [31:0]   mem_wdata,
   output logic          mem_write_en,
   output logic          mem_read_en,
   output logic [3:0]    mem_byte_enable,
   input  logic [31:0]   mem_read_data
);

   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic        owner_q, owner_d;
   logic        rv_pend_q, rv_pend_d;
   logic        err_pend_q, err_pend_d;

   logic        p1_turn;
   logic        gnt0, gnt1, granted;
   logic        sel_we;
   logic [31:0] sel_addr, sel_wdata;
   logic [1:0]  sel_size;
   logic        aligned;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata;
   logic [31:0] rsp_data;

   assign p1_turn = (wait_cnt_q == 4'(MAX_WAIT));

   // Grants are suppressed while reset is held so nothing reaches the memory.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst_n) begin
         if (p0.req && !(p1.req && p1_turn)) gnt0 = 1'b1;
         else if (p1.req)                     gnt1 = 1'b1;
      end
   end

   assign granted   = gnt0 | gnt1;
   assign sel_we    = gnt1 ? p1.we    : p0.we;
   assign sel_addr  = gnt1 ? p1.addr  : p0.addr;
   assign sel_size  = gnt1 ? p1.size  : p0.size;
   assign sel_wdata = gnt1 ? p1.wdata : p0.wdata;

   always_comb begin
      aligned    = 1'b0;
      lane_be    = 4'b0000;
      lane_wdata = sel_wdata;
      unique case (sel_size)
         2'b00: begin
            aligned    = 1'b1;
            lane_be    = 4'b0001 << sel_addr[1:0];
            lane_wdata = {4{sel_wdata[7:0]}};
         end
         2'b01: begin
            aligned    = ~sel_addr[0];
            lane_be    = sel_addr[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{sel_wdata[15:0]}};
         end
         2'b10: begin
            aligned    = (sel_addr[1:0] == 2'b00);
            lane_be    = 4'b1111;
         end
         default: aligned = 1'b0;
      endcase
   end

   assign mem_addr        = granted ? sel_addr : 32'h0;
   assign mem_wdata       = granted ? lane_wdata : 32'h0;
   assign mem_write_en    = granted &&  sel_we && aligned;
   assign mem_read_en     = granted && !sel_we && aligned;
   assign mem_byte_enable = (granted && aligned) ? lane_be : 4'b0000;

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!p1.req || gnt1)          wait_cnt_d = 4'd0;
      else if (!p1_turn)            wait_cnt_d = wait_cnt_q + 4'd1;
      owner_d    = gnt1 ? 1'b1 : (gnt0 ? 1'b0 : owner_q);
      rv_pend_d  = granted && !sel_we;
      err_pend_d = granted && !aligned;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments; reset is synchronous to clk.
      if (!rst_n) begin
         wait_cnt_q <= 4'd0;
         owner_q    <= 1'b0;
         rv_pend_q  <= 1'b0;
         err_pend_q <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         owner_q    <= owner_d;
         rv_pend_q  <= rv_pend_d;
         err_pend_q <= err_pend_d;
      end
   end

   // A misaligned load still answers with rvalid, but carries no data.
   assign rsp_data = (rv_pend_q && !err_pend_q) ? mem_read_data : 32'h0;

   assign p0.gnt    = gnt0;
   assign p1.gnt    = gnt1;
   assign p0.rvalid = rv_pend_q  && !owner_q;
   assign p0.err    = err_pend_q && !owner_q;
   assign p0.rdata  = owner_q ? 32'h0 : rsp_data;
   assign p1.rvalid = rv_pend_q  && owner_q;
   assign p1.err    = err_pend_q && owner_q;
   assign p1.rdata  = owner_q ? rsp_data : 32'h0;

endmodule
